mem_master: RTL
===============

Name: mem_master

Overview:
- Initiator-side sequencer that drives the 16-bit-word, 12-bit-address memory (Read/Write/address/data_in/data_out) on behalf of the CPU control unit.
- Accepts single-word write requests and 1..2^LEN_W-word sequential read bursts over a valid/ready request port.
- Generates the memory strobes with programmable wait states.
- Returns read words as one-cycle response pulses.
- Sits between the control unit (fetch/operand/store sequencing) and the memory.

Parameters:
- ADDR_W, 12, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 16, memory word width.
- LEN_W, 4, burst-length field width; beats = req_len+1.
- WAIT_CYCLES, 0, extra cycles each beat holds the strobe before completing (0..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle and able to accept.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data (writes only).
- req_len  in  LEN_W  read burst length minus one; ignored for writes.
- rsp_valid  out  1  one-cycle pulse, rsp_rdata valid.
- rsp_rdata  out  DATA_W  captured read word.
- done  out  1  one-cycle pulse when the whole transaction completes.
- busy  out  1  transaction in progress (ACCESS state).
- mem_read  out  1  memory Read strobe.
- mem_write  out  1  memory Write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; may be Z when mem_read=0.

Behaviour:
- Clocking and reset are fixed:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - Assertion immediately clears every output: req_ready=0, rsp_valid=0, rsp_rdata=0, done=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - After deassertion the FSM is in IDLE; req_ready=1 from the first clock edge after release.
- States: IDLE, ACCESS.
- IDLE:
  - req_ready=1; mem_read=mem_write=0.
  - Handshake at edge where req_valid&req_ready. That edge latches we_q, addr_q=req_addr, wdata_q=req_wdata, beats_left=req_len (writes force 0), wait_cnt=WAIT_CYCLES, and moves to ACCESS.
- ACCESS:
  - req_ready=0; busy=1; mem_addr=addr_q; mem_wdata=wdata_q.
  - Read: mem_read=1 for every cycle of every beat (held across wait states; address stable).
  - Write: mem_write=1 only in the final cycle of the beat (wait_cnt==0), so memory is written exactly once.
  - wait_cnt decrements each cycle while >0. The beat completes on the edge where wait_cnt==0.
- Beat completion:
  - Read: rsp_rdata<=mem_rdata and rsp_valid pulses for the following cycle.
  - If beats_left==0: go to IDLE and done pulses for the following cycle (same cycle as the last rsp_valid for reads).
  - Otherwise: addr_q<=addr_q+1 (4095 wraps to 0), beats_left-1, wait_cnt reloaded; stay in ACCESS.
- Latency:
  - Handshake at edge k with WAIT_CYCLES=W: first beat strobes in cycles k..k+W, first rsp_valid in cycle k+W+1.
  - Subsequent beats follow every W+1 cycles with no bubble.
  - A new request is accepted at the edge ending the cycle in which done=1, so back-to-back transactions have zero idle gap.
- rsp_rdata holds its last value between pulses.
- mem_rdata is sampled only at read-beat completion; Z/X at other times has no effect.
- req_* inputs are ignored outside IDLE; no request queuing.
- Reset mid-transaction aborts it: strobes drop asynchronously, and no done or rsp_valid is issued.
- Max burst (req_len=all ones) yields 2^LEN_W beats.

Decomposition:
- Shared package/include holds:
  - state encoding localparams ST_IDLE/ST_ACCESS;
  - ADDR_W/DATA_W defaults, shared with the memory and CPU datapath.
- Natural sub-module: mem_beat_timer, the wait-state down-counter with load/zero flag, reusable by other bus initiators.
- Everything else is flat.

Test Plan:
- Memory preset [0]=3002,[1]=1003,[2]=0007,[3]=0005; W=0, read addr 0 len 3 → rsp_valid 4 consecutive cycles with 3002,1003,0007,0005; done coincides with the 4th; mem_read high exactly 4 cycles.
- Write addr 2 data ABCD, then read addr 2 len 0 → mem_write high exactly 1 cycle; read returns ABCD; second request accepted with no idle cycle after done.
- WAIT_CYCLES=2, read addr 1 len 1 → mem_read high 6 cycles; rsp_valid at handshake+3 (1003) and +6 (0007); write variant strobes mem_write only in the 3rd cycle.
- Read addr FFF len 1 → mem_addr FFF then 000; second word = mem[0]=3002.
- rst_n dropped mid-burst (after beat 2 of 4) → mem_read, busy, rsp_valid drop immediately with no further pulses; after release req_ready=1 and a new read of addr 3 returns 0005.
- req_valid held during ACCESS with changing req_addr → ignored until done; mem_addr tracks only the latched burst.

Source files
------------

// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared widths and state encoding for the memory sequencer
//   ADDR_W_DEF / DATA_W_DEF / LEN_W_DEF : default widths shared with memory and CPU datapath
//   WAIT_CNT_W                          : width of the wait-state counter (0..15)
//   state_t                             : ST_IDLE / ST_ACCESS
package mem_master_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 4;
    localparam int WAIT_CNT_W = 4;
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;
endpackage

// File: rtl/mem_beat_timer.sv
// mem_beat_timer: wait-state down-counter with load and zero flag
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : reload counter with load_val_i (has priority over counting)
//   load_val_i  : value to load
//   zero_o      : counter is zero (current beat completes this cycle)
module mem_beat_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_master.sv
// mem_master: request-driven memory sequencer for single writes and sequential read bursts
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (accepted only while idle)
//   req_we/addr/wdata/len      : request fields; len = beats-1, ignored for writes
//   rsp_valid/rsp_rdata        : one-cycle read-word pulse, data held between pulses
//   done                       : one-cycle pulse after the last beat
//   busy                       : transaction in progress
//   mem_read/write/addr/wdata  : memory strobes, address and write data
//   mem_rdata                  : memory read data, sampled only at read-beat completion
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              done,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            state_q;
    logic              ready_q;
    logic              we_q;
    logic              rsp_valid_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LEN_W-1:0]  beats_q;
    logic              wait_zero;
    logic              handshake;
    logic              beat_end;
    logic              last_beat;

    assign handshake = (state_q == ST_IDLE) && ready_q && req_valid;
    assign beat_end  = (state_q == ST_ACCESS) && wait_zero;
    assign last_beat = (beats_q == '0);

    // Reload on acceptance and between beats so consecutive beats run without a bubble
    mem_beat_timer #(
        .CNT_W(WAIT_CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (handshake || (beat_end && !last_beat)),
        .load_val_i(WAIT_CNT_W'(WAIT_CYCLES)),
        .zero_o    (wait_zero)
    );

    // ready_q is registered so it stays low during reset and rises at the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            beats_q     <= '0;
        end else begin
            rsp_valid_q <= beat_end && !we_q;
            done_q      <= beat_end && last_beat;
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        state_q <= ST_ACCESS;
                        ready_q <= 1'b0;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        beats_q <= req_we ? '0 : req_len;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (beat_end) begin
                        if (!we_q)
                            rdata_q <= mem_rdata;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            beats_q <= beats_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = (state_q == ST_ACCESS);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign done      = done_q;
    assign mem_read  = busy && !we_q;
    // Write strobe only in the final cycle of the beat so the word is written once
    assign mem_write = busy && we_q && wait_zero;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule
